bp_me_data_resp_reassembler: RTL and testbench

Receives the serialized LCE data response stream, one flit per beat, at the CCE-side egress of the coherence network. Rebuilds each full `bp_lce_cce_data_resp` packet from `num_packets_p` flits and presents it to the CCE on a valid/yumi interface. It is the receive counterpart of the LCE-side packet serializer and sits between the data-response network output and `bp_cce_top`.

---
 rtl/bp_me_data_resp_reassembler.sv | 52 +++++
 tb/tb_bp_me_data_resp_reassembler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_data_resp_reassembler.sv
// bp_me_data_resp_reassembler: rebuilds LCE data response packets from serialized flits for the CCE
module bp_me_data_resp_reassembler #(
  parameter int data_width_p = 536,
  parameter int num_packets_p = 8,
  localparam int flit_width_lp = (data_width_p + num_packets_p - 1) / num_packets_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [flit_width_lp-1:0] flit_i,
  input  logic                     flit_v_i,
  input  logic                     flit_last_i,
  output logic                     flit_ready_o,
  output logic [data_width_p-1:0]  data_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic                     err_o
);
  localparam int cnt_w = $clog2(num_packets_p);
  typedef enum logic {COLLECT, FULL} state_e;
  state_e state_r, state_n;
  logic [cnt_w-1:0] cnt_r, cnt_n;
  logic [data_width_p-1:0] data_r, data_n;
  logic err_r, err_n, accept, is_final, done;
  assign flit_ready_o = reset_n_i & (state_r == COLLECT);
  assign accept = flit_v_i & flit_ready_o;
  assign is_final = cnt_r == cnt_w'(num_packets_p - 1);
  assign done = accept & (flit_last_i | is_final);
  assign v_o = state_r == FULL;
  assign data_o = data_r;
  assign err_o = err_r;
  always_comb begin
    state_n = state_r == FULL ? (yumi_i ? COLLECT : FULL) : (done ? FULL : COLLECT);
    cnt_n = done ? '0 : accept ? cnt_r + 1'b1 : cnt_r;
    data_n = (state_r == FULL && yumi_i) ? '0
           : accept ? data_r | (data_width_p'(flit_i) << (int'(cnt_r) * flit_width_lp))
           : data_r;
    err_n = accept & (flit_last_i ^ is_final);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= COLLECT;
      cnt_r <= '0;
      data_r <= '0;
      err_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r <= cnt_n;
      data_r <= data_n;
      err_r <= err_n;
    end
  end
endmodule

// File: tb/tb_bp_me_data_resp_reassembler.sv
// tb_bp_me_data_resp_reassembler: directed and random checks of packet reassembly
module tb_bp_me_data_resp_reassembler;
  logic clk = 0;
  logic reset_n = 0;
  logic [5:0] flit = '0;
  logic flit_v = 0;
  logic flit_last = 0;
  logic ready;
  logic [21:0] data;
  logic v;
  logic yumi = 0;
  logic err;
  int passed = 0;
  int total = 0;
  logic [21:0] exp_q[$];
  int got = 0;
  bp_me_data_resp_reassembler #(.data_width_p(22), .num_packets_p(4)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .flit_i(flit),
    .flit_v_i(flit_v),
    .flit_last_i(flit_last),
    .flit_ready_o(ready),
    .data_o(data),
    .v_o(v),
    .yumi_i(yumi),
    .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send(input logic [5:0] f, input logic l);
    int n = 0;
    flit = f;
    flit_last = l;
    flit_v = 1;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    flit_v = 0;
    flit_last = 0;
  endtask
  task automatic consume();
    yumi = 1;
    @(posedge clk);
    #1;
    yumi = 0;
  endtask
  initial begin
    logic [21:0] held;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_v", v, 0);
    check("rst_data", data, 0);
    check("rst_err", err, 0);
    reset_n = 1;
    #1;
    check("post_rst_ready", ready, 1);
    yumi = 1;
    send(6'h15, 0);
    send(6'h2A, 0);
    send(6'h3F, 0);
    check("basic_v_early", v, 0);
    yumi = 0;
    send(6'h0C, 1);
    check("basic_v", v, 1);
    check("basic_data", data, 22'h33FA95);
    check("basic_err", err, 0);
    check("basic_ready_full", ready, 0);
    consume();
    check("basic_v_after_yumi", v, 0);
    check("basic_ready_after_yumi", ready, 1);
    send(6'h11, 0);
    send(6'h22, 0);
    send(6'h33, 0);
    send(6'h03, 1);
    held = data;
    check("bp_data", data, 22'h0F3891);
    flit = 6'h05;
    flit_last = 0;
    flit_v = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ready", ready, 0);
      check("bp_hold", {v, data}, {1'b1, held});
    end
    @(posedge clk);
    #1;
    yumi = 1;
    @(posedge clk);
    #1;
    yumi = 0;
    check("bp_ready_after", ready, 1);
    @(posedge clk);
    #1;
    flit_v = 0;
    check("bp_v_mid", v, 0);
    send(6'h06, 0);
    send(6'h07, 0);
    send(6'h08, 1);
    check("bp_next_data", data, 22'h207185);
    consume();
    send(6'h01, 0);
    check("early_err_pre", err, 0);
    send(6'h02, 1);
    check("early_v", v, 1);
    check("early_err", err, 1);
    check("early_data", data, 22'h000081);
    @(posedge clk);
    #1;
    check("early_err_drop", err, 0);
    consume();
    send(6'h3F, 0);
    send(6'h00, 0);
    send(6'h2A, 0);
    send(6'h05, 1);
    check("clean_data", data, 22'h16A03F);
    check("clean_err", err, 0);
    consume();
    send(6'h01, 0);
    send(6'h02, 0);
    send(6'h03, 0);
    check("miss_v_early", v, 0);
    send(6'h04, 0);
    check("miss_v", v, 1);
    check("miss_err", err, 1);
    check("miss_data", data, 22'h103081);
    @(posedge clk);
    #1;
    check("miss_err_drop", err, 0);
    consume();
    send(6'h3F, 0);
    send(6'h3F, 0);
    reset_n = 0;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_v", v, 0);
    @(posedge clk);
    #1;
    check("mid_rst_v_clk", v, 0);
    reset_n = 1;
    #1;
    check("mid_rst_ready_after", ready, 1);
    send(6'h01, 0);
    send(6'h01, 0);
    send(6'h01, 0);
    send(6'h01, 1);
    check("mid_rst_data", data, 22'h041041);
    consume();
    fork
      begin
        for (int p = 0; p < 50; p++) begin
          int len;
          logic [21:0] e;
          logic [5:0] f;
          len = $urandom_range(1, 4);
          e = '0;
          for (int k = 0; k < len; k++) begin
            f = 6'($urandom);
            e = e | (22'(f) << (6 * k));
          end
          exp_q.push_back(e);
          for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            f = 6'(e >> (6 * k));
            if (k == 3) f = 6'($urandom_range(0, 3) == 0 ? 6'(flit) : f);
            if (k == 3) f = 6'(e >> 18) | (f & 6'h30);
            send(f, k == len - 1 ? (len < 4 ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0);
          end
        end
      end
      begin
        int cyc = 0;
        logic prev_v = 0;
        logic prev_y = 0;
        logic [21:0] want;
        while (got < 50 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (prev_v && !prev_y) check("v_hold", v, 1);
          prev_v = v;
          if (v) begin
            yumi = $urandom_range(0, 2) == 0;
            if (yumi) begin
              want = exp_q.size() > 0 ? exp_q.pop_front() : 22'h3FFFFF;
              check($sformatf("stream_pkt%0d", got), data, want);
              got++;
            end
          end else yumi = 0;
          prev_y = yumi;
        end
        if (cyc >= 20000) check("stream_timeout", 1, 0);
        @(posedge clk);
        #1;
        yumi = 0;
      end
    join
    check("stream_count", got, 50);
    check("stream_leftover", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("stream_no_extra", v, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
